// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state set, opcodes, ALU codes
// and datapath select values. ImmSrc codes are also consumed by the immediate extender.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR     = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // How the ALU operation is chosen in a given state
    localparam logic [1:0] ACLS_ADD   = 2'b00;
    localparam logic [1:0] ACLS_SUB   = 2'b01;
    localparam logic [1:0] ACLS_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_B = 2'b01;
    localparam logic [1:0] IMM_S = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    function automatic logic branch_taken(
        input logic [2:0] funct3,
        input logic       zero,
        input logic       lt
    );
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation select from the state's ALU class and the instruction
// function fields.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       rtype,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_class)
            ACLS_SUB: alu_control = ALU_SUB;
            ACLS_FUNCT: begin
                case (funct3)
                    // I-type never subtracts: bit 30 is part of the immediate there
                    3'b000:  alu_control = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: one state per cycle, datapath selects decoded from
// state, memory waits via MemReady, branch decision from ALU flags.
//
// state      | meaning
// -----------+----------------------------------------------------
// FETCH      | read instruction at PC, PC+4 -> PC when MemReady
// DECODE     | compute OldPC+imm into ALUOut, dispatch on opcode
// MEMADR     | A + imm -> effective address for lw/sw
// MEMREAD    | load access, waits for MemReady
// MEMWB      | write loaded data to rd
// MEMWRITE   | store access, MemWrite held until MemReady
// EXECR      | register-register ALU op
// EXECI      | register-immediate ALU op
// ALUWB      | write ALUOut to rd
// BRANCH     | A - B, load PC with target when taken
// JALR       | A + imm -> ALUOut as jump target
// JUMP       | PC <- ALUOut, compute OldPC+4 for the link register
// ILLEGAL    | unsupported opcode, absorbing until reset
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Inst,
    input  logic        MemReady,
    input  logic        Zero,
    input  logic        Lt,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic        Illegal
);

    state_t     state;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [1:0] alu_class;
    logic       rtype;
    logic [2:0] alu_ctl;
    logic       inst_unused;

    assign op          = Inst[6:0];
    assign funct3      = Inst[14:12];
    assign funct7b5    = Inst[30];
    assign inst_unused = ^{Inst[31], Inst[29:15], Inst[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            case (state)
                S_FETCH:    state <= MemReady ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_ITYPE:          state <= S_EXECI;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JUMP;
                        OP_JALR:           state <= S_JALR;
                        default:           state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR:   state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state <= MemReady ? S_MEMWB : S_MEMREAD;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= MemReady ? S_FETCH : S_MEMWRITE;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JALR:     state <= S_JUMP;
                S_JUMP:     state <= S_ALUWB;
                S_ILLEGAL:  state <= S_ILLEGAL;
                default:    state <= RESET_STATE;
            endcase
        end
    end

    mc_alu_decoder u_alu_decoder (
        .alu_class   (alu_class),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .rtype       (rtype),
        .alu_control (alu_ctl)
    );

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = ADR_PC;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REG;
        ImmSrc    = IMM_I;
        RegWrite  = 1'b0;
        Illegal   = 1'b0;
        alu_class = ACLS_ADD;
        rtype     = 1'b0;
        case (state)
            S_FETCH: begin
                AdrSrc    = ADR_PC;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                AdrSrc    = ADR_RESULT;
                ResultSrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = ADR_RESULT;
                ResultSrc = RES_ALUOUT;
                MemWrite  = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_REG;
                alu_class = ACLS_FUNCT;
                rtype     = 1'b1;
            end
            S_EXECI: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_I;
                alu_class = ACLS_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_REG;
                alu_class = ACLS_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = branch_taken(funct3, Zero, Lt);
            end
            S_JALR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
            end
            S_JUMP: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
            end
            S_ILLEGAL: Illegal = 1'b1;
            default: ;
        endcase
        // Reset must silence strobes in the very cycle it asserts, before the clock
        if (!rst_n) begin
            PCWrite   = 1'b0;
            AdrSrc    = ADR_PC;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            ResultSrc = RES_ALUOUT;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_REG;
            ImmSrc    = IMM_I;
            RegWrite  = 1'b0;
            Illegal   = 1'b0;
            alu_class = ACLS_ADD;
            rtype     = 1'b0;
        end
    end

    assign ALUControl = rst_n ? alu_ctl : ALU_ADD;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle
// and compares the full control word against hand-written expectations.
module tb_mc_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [31:0] Inst;
    logic        MemReady;
    logic        Zero;
    logic        Lt;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic        RegWrite;
    logic        Illegal;

    int n_vec;
    int n_err;

    mc_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Inst       (Inst),
        .MemReady   (MemReady),
        .Zero       (Zero),
        .Lt         (Lt),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,Illegal}
    logic [16:0] snap;
    assign snap = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, RegWrite, Illegal};

    function automatic logic [16:0] v(
        input logic pcw, input logic adr, input logic mw, input logic irw,
        input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
        input logic [2:0] alu, input logic [1:0] imm, input logic rw, input logic ill
    );
        return {pcw, adr, mw, irw, res, sa, sb, alu, imm, rw, ill};
    endfunction

    function automatic logic [16:0] fetch_w(input logic mr);
        return v(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
    endfunction

    function automatic logic [16:0] decode_w(input logic [1:0] imm);
        return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
    endfunction

    localparam logic [16:0] ALUWB_W  = 17'b0_0_0_0_00_00_00_000_00_1_0;
    localparam logic [16:0] MEMRD_W  = 17'b0_1_0_0_00_00_00_000_00_0_0;
    localparam logic [16:0] MEMWB_W  = 17'b0_0_0_0_01_00_00_000_00_1_0;
    localparam logic [16:0] MEMWR_W  = 17'b0_1_1_0_00_00_00_000_00_0_0;
    localparam logic [16:0] JUMP_W   = 17'b1_0_0_0_00_01_10_000_00_0_0;
    localparam logic [16:0] JALR_W   = 17'b0_0_0_0_00_10_01_000_00_0_0;
    localparam logic [16:0] ILL_W    = 17'b0_0_0_0_00_00_00_000_00_0_1;
    localparam logic [16:0] QUIET_W  = 17'b0;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sample mid-cycle, then move to just after the next rising edge
    task automatic step(input string tag, input logic [16:0] exp);
        @(negedge clk);
        check(tag, snap, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_branch(input string tag, input logic [31:0] inst,
                              input logic z, input logic l, input logic taken);
        Inst = inst; Zero = z; Lt = l; MemReady = 1'b1;
        step({tag, ".fetch"}, fetch_w(1'b1));
        step({tag, ".decode"}, decode_w(2'b01));
        step({tag, ".branch"}, v(taken, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0));
    endtask

    task automatic run_alu(input string tag, input logic [31:0] inst,
                           input logic [1:0] srcb, input logic [2:0] alu);
        Inst = inst; MemReady = 1'b1;
        step({tag, ".fetch"}, fetch_w(1'b1));
        step({tag, ".decode"}, decode_w(2'b01));
        step({tag, ".exec"}, v(0, 0, 0, 0, 2'b00, 2'b10, srcb, alu, 2'b00, 0, 0));
        step({tag, ".aluwb"}, ALUWB_W);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        MemReady = 1'b1;
        Zero = 1'b0;
        Lt = 1'b0;
        Inst = 32'h00500093;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset.quiet", snap, QUIET_W);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // addi x1,x0,5
        run_alu("addi", 32'h00500093, 2'b01, 3'b000);

        // lw with two wait cycles in MEMREAD
        Inst = 32'h0002a303; MemReady = 1'b1;
        step("lw.fetch", fetch_w(1'b1));
        step("lw.decode", decode_w(2'b01));
        step("lw.memadr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        MemReady = 1'b0;
        step("lw.memread0", MEMRD_W);
        step("lw.memread1", MEMRD_W);
        MemReady = 1'b1;
        step("lw.memread2", MEMRD_W);
        step("lw.memwb", MEMWB_W);

        // sw with one fetch wait and one store wait
        Inst = 32'h0022a423; MemReady = 1'b0;
        step("sw.fetch_wait", fetch_w(1'b0));
        MemReady = 1'b1;
        step("sw.fetch", fetch_w(1'b1));
        step("sw.decode", decode_w(2'b01));
        step("sw.memadr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b10, 0, 0));
        MemReady = 1'b0;
        step("sw.memwrite0", MEMWR_W);
        MemReady = 1'b1;
        step("sw.memwrite1", MEMWR_W);

        run_branch("beq_t",  32'h00208463, 1'b1, 1'b0, 1'b1);
        run_branch("beq_nt", 32'h00208463, 1'b0, 1'b1, 1'b0);
        run_branch("bne_nt", 32'h00209463, 1'b1, 1'b0, 1'b0);
        run_branch("bne_t",  32'h00209463, 1'b0, 1'b0, 1'b1);
        run_branch("blt_t",  32'h0020c463, 1'b0, 1'b1, 1'b1);
        run_branch("bge_nt", 32'h0020d463, 1'b0, 1'b1, 1'b0);
        run_branch("b010",   32'h0020a463, 1'b1, 1'b1, 1'b0);

        run_alu("sub",  32'h40208033, 2'b00, 3'b001);
        run_alu("add",  32'h00208033, 2'b00, 3'b000);
        run_alu("and",  32'h0020f033, 2'b00, 3'b010);
        run_alu("or",   32'h0020e033, 2'b00, 3'b011);
        run_alu("slt",  32'h0020a033, 2'b00, 3'b101);
        run_alu("addi_b30", 32'h40500093, 2'b01, 3'b000);
        run_alu("slli", 32'h00109093, 2'b01, 3'b000);

        // jal
        Inst = 32'h008000ef; MemReady = 1'b1;
        step("jal.fetch", fetch_w(1'b1));
        step("jal.decode", decode_w(2'b11));
        step("jal.jump", JUMP_W);
        step("jal.aluwb", ALUWB_W);

        // jalr
        Inst = 32'h000080e7;
        step("jalr.fetch", fetch_w(1'b1));
        step("jalr.decode", decode_w(2'b01));
        step("jalr.jalr", JALR_W);
        step("jalr.jump", JUMP_W);
        step("jalr.aluwb", ALUWB_W);

        // reset asserted while a store is waiting
        Inst = 32'h0022a423; MemReady = 1'b1;
        step("swr.fetch", fetch_w(1'b1));
        step("swr.decode", decode_w(2'b01));
        step("swr.memadr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b10, 0, 0));
        MemReady = 1'b0;
        @(negedge clk);
        check("swr.memwrite", snap, MEMWR_W);
        #1;
        rst_n = 1'b0;
        #1;
        check("swr.abort", snap, QUIET_W);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        MemReady = 1'b1;
        Inst = 32'h0000007f;
        step("ill.fetch", fetch_w(1'b1));
        step("ill.decode", decode_w(2'b01));
        for (int i = 0; i < 10; i++) begin
            Zero = i[0];
            Lt = i[1];
            MemReady = i[2] | i[0];
            step($sformatf("ill.hold%0d", i), ILL_W);
        end

        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("ill.reset", snap, QUIET_W);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        MemReady = 1'b1;
        Inst = 32'h00500093;
        step("post.fetch", fetch_w(1'b1));
        step("post.decode", decode_w(2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
